// File: rtl/period_meter.sv
// period_meter: measures sig_in period in clk_in cycles; PERIOD_METER_HIGH_TIME_EN adds high_out
module period_meter #(
  parameter int N = 32
) (
  input  logic         clk_in,
  input  logic         rst,
  input  logic         en,
  input  logic         sig_in,
  output logic [N-1:0] period_out,
  output logic         period_valid,
  output logic         overflow
`ifdef PERIOD_METER_HIGH_TIME_EN
  ,
  output logic [N-1:0] high_out
`endif
);
  typedef enum logic {ARM, MEASURE} state_e;
  localparam logic [N-1:0] MAX = '1;
  localparam logic [N-1:0] ONE = N'(1);
  state_e state_q, state_d;
  logic s1_q, s2_q, s3_q;
  logic rise, report, ovf_set;
  logic [N-1:0] cnt_q, cnt_d, period_q, period_d;
  logic valid_q, valid_d, ovf_q, ovf_d;
  assign rise = s2_q & ~s3_q;
  // synchronizer and edge-detect history
  always_ff @(posedge clk_in) begin
    if (rst) {s1_q, s2_q, s3_q} <= '0;
    else {s1_q, s2_q, s3_q} <= {sig_in, s1_q, s2_q};
  end
  // state register
  always_ff @(posedge clk_in) begin
    if (rst) state_q <= ARM;
    else state_q <= state_d;
  end
  // next state: en low always drops back to ARM, a rise beats saturation
  always_comb begin
    state_d = state_q == ARM ? (rise && en ? MEASURE : ARM)
                             : (!en || (!rise && cnt_q == MAX) ? ARM : MEASURE);
  end
  // FSM outputs: report on a rise while measuring, flag a saturated period
  always_comb begin
    report = state_q == MEASURE && en && rise;
    ovf_set = state_q == MEASURE && en && !rise && cnt_q == MAX;
  end
  // datapath next values: counter restarts at 1 on a rise and never wraps
  always_comb begin
    cnt_d = rise ? ONE : (cnt_q == MAX ? MAX : cnt_q + ONE);
    period_d = report ? cnt_q : period_q;
    valid_d = report;
    ovf_d = ovf_q | ovf_set;
  end
  // datapath registers
  always_ff @(posedge clk_in) begin
    if (rst) begin
      cnt_q <= '0;
      period_q <= '0;
      valid_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      period_q <= period_d;
      valid_q <= valid_d;
      ovf_q <= ovf_d;
    end
  end
  assign period_out = period_q;
  assign period_valid = valid_q;
  assign overflow = ovf_q;
`ifdef PERIOD_METER_HIGH_TIME_EN
  logic [N-1:0] hcnt_q, hcnt_d, high_q, high_d;
  // high-time counter restarts at the current level on a rise and saturates
  always_comb begin
    hcnt_d = rise ? N'(s2_q) : (hcnt_q == MAX ? MAX : hcnt_q + N'(s2_q));
    high_d = report ? hcnt_q : high_q;
  end
  // high-time registers
  always_ff @(posedge clk_in) begin
    if (rst) begin
      hcnt_q <= '0;
      high_q <= '0;
    end else begin
      hcnt_q <= hcnt_d;
      high_q <= high_d;
    end
  end
  assign high_out = high_q;
`endif
endmodule

// File: tb/tb_period_meter.sv
// tb_period_meter: directed checks of period_meter with N=8
module tb_period_meter;
  localparam int N = 8;
  logic clk = 1'b0;
  logic rst, en, sig_in;
  logic [N-1:0] period_out;
  logic period_valid, overflow;
  int vec = 0;
  int miss = 0;
  int nv = 0;
  int consec = 0;
  logic prevv = 1'b0;
  logic [N-1:0] lastp = '0;
`ifdef PERIOD_METER_HIGH_TIME_EN
  logic [N-1:0] high_out;
  logic [N-1:0] lasth = '0;
`endif

  period_meter #(.N(N)) dut (
    .clk_in(clk),
    .rst(rst),
    .en(en),
    .sig_in(sig_in),
    .period_out(period_out),
    .period_valid(period_valid),
    .overflow(overflow)
`ifdef PERIOD_METER_HIGH_TIME_EN
    ,
    .high_out(high_out)
`endif
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
    if (period_valid) begin
      nv++;
      lastp = period_out;
`ifdef PERIOD_METER_HIGH_TIME_EN
      lasth = high_out;
`endif
      if (prevv) consec++;
    end
    prevv = period_valid;
  endtask

  task automatic wave(input int h, input int l);
    repeat (h) begin sig_in = 1'b1; cyc(); end
    repeat (l) begin sig_in = 1'b0; cyc(); end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; sig_in = 1'b0;
    cyc(); cyc();
    rst = 1'b0;
    chk("rst_period", period_out, 0);
    chk("rst_valid", period_valid, 0);
    chk("rst_ovf", overflow, 0);
`ifdef PERIOD_METER_HIGH_TIME_EN
    chk("rst_high", high_out, 0);
`endif
    // steady 10-cycle wave, first rise only arms
    nv = 0; consec = 0;
    wave(5, 5);
    chk("t1_first_rise_silent", nv, 0);
    sig_in = 1'b1;
    cyc(); chk("t1_lat_edge1", period_valid, 0);
    cyc(); chk("t1_lat_edge2", period_valid, 0);
    cyc(); chk("t1_lat_edge3", period_valid, 1);
    chk("t1_lat_period", period_out, 10);
    repeat (2) cyc();
    sig_in = 1'b0;
    repeat (5) cyc();
    wave(5, 5); wave(5, 5);
    chk("t1_reports", nv, 3);
    chk("t1_period", lastp, 10);
    chk("t1_no_back_to_back", consec, 0);
    // reset mid-period
    sig_in = 1'b0;
    repeat (3) cyc();
    rst = 1'b1; cyc(); rst = 1'b0;
    chk("t2_period", period_out, 0);
    chk("t2_valid", period_valid, 0);
    chk("t2_ovf", overflow, 0);
    nv = 0;
    cyc();
    wave(5, 5);
    chk("t2_one_rise", nv, 0);
    wave(5, 5);
    chk("t2_two_rises", nv, 1);
    chk("t2_period_after", lastp, 10);
    // overflow on a long low stretch
    repeat (5) begin sig_in = 1'b1; cyc(); end
    nv = 0;
    sig_in = 1'b0;
    repeat (300) cyc();
    chk("t3_ovf_set", overflow, 1);
    chk("t3_no_report", nv, 0);
    wave(5, 5);
    chk("t3_ovf_sticky", overflow, 1);
    chk("t3_rearm_silent", nv, 0);
    wave(5, 5);
    chk("t3_report", nv, 1);
    chk("t3_period", lastp, 10);
    chk("t3_ovf_still", overflow, 1);
    // en dropped for three cycles mid-period
    repeat (5) begin sig_in = 1'b1; cyc(); end
    nv = 0;
    sig_in = 1'b0; en = 1'b0;
    repeat (3) cyc();
    en = 1'b1;
    repeat (2) cyc();
    wave(5, 5);
    chk("t4_dropped", nv, 0);
    wave(5, 5);
    chk("t4_report", nv, 1);
    chk("t4_period", lastp, 10);
    // en falling in the same cycle as a rise
    sig_in = 1'b1;
    cyc(); cyc();
    en = 1'b0;
    cyc();
    chk("t4_en_rise_valid", period_valid, 0);
    en = 1'b1;
    cyc(); cyc();
    sig_in = 1'b0;
    repeat (5) cyc();
    nv = 0;
    wave(5, 5);
    chk("t4_en_rise_rearm", nv, 0);
    wave(5, 5);
    chk("t4_en_rise_report", nv, 1);
    // minimum period 2 and maximum 255 without overflow
    rst = 1'b1; cyc(); rst = 1'b0;
    chk("t5_ovf_cleared", overflow, 0);
    nv = 0; consec = 0;
    repeat (10) wave(1, 1);
    chk("t5_p2_reports", nv, 8);
    chk("t5_p2_period", lastp, 2);
    chk("t5_p2_spacing", consec, 0);
    wave(1, 254);
    nv = 0;
    wave(1, 254);
    chk("t5_p255_report", nv, 1);
    chk("t5_p255_period", lastp, 255);
    chk("t5_p255_no_ovf", overflow, 0);
    // 3 high / 7 low
    wave(3, 7);
    nv = 0;
    wave(3, 7); wave(3, 7);
    chk("t6_reports", nv, 2);
    chk("t6_period", lastp, 10);
`ifdef PERIOD_METER_HIGH_TIME_EN
    chk("t6_high", lasth, 3);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
